// File: rtl/windowed_register_file.sv
// SPARC integer register file with overlapping register windows.
// Architectural selects r0..r31 are mapped through the Current Window
// Pointer onto a physical array of 8 globals plus 16 words per window.
// The block also owns CWP/WIM and raises window overflow/underflow
// pulses when SAVE/RESTORE would rotate into an invalid window.
module windowed_register_file #(
    parameter int NWINDOWS = 4,
    parameter int DATA_W   = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [4:0]          Register_A_Sel,
    input  logic [4:0]          Register_B_Sel,
    input  logic [4:0]          Register_C_Sel,
    input  logic [DATA_W-1:0]   Data_In,
    input  logic                RF_Write,
    input  logic                Save,
    input  logic                Restore,
    input  logic                CWP_Load,
    input  logic [4:0]          CWP_In,
    input  logic                WIM_Load,
    input  logic [31:0]         WIM_In,
    output logic [DATA_W-1:0]   Port_A,
    output logic [DATA_W-1:0]   Port_B,
    output logic [4:0]          CWP,
    output logic [NWINDOWS-1:0] WIM,
    output logic                Window_Overflow,
    output logic                Window_Underflow
);

    localparam int WIN_SPAN = 16 * NWINDOWS;          // windowed words
    localparam int NPHYS    = 8 + WIN_SPAN;           // globals + windows
    localparam int PHYS_W   = $clog2(NPHYS);
    localparam int OFF_W    = $clog2(2 * WIN_SPAN);   // holds offset before wrap

    logic [DATA_W-1:0] regs [NPHYS];

    // Globals map straight through; r8..r31 slide by 16 words per window
    // and wrap around the windowed region so ins alias the next window's outs.
    function automatic logic [PHYS_W-1:0] map_addr(input logic [4:0] r,
                                                   input logic [4:0] w);
        logic [OFF_W-1:0] off;
        if (r < 5'd8) begin
            return PHYS_W'(r);
        end
        off = OFF_W'({w, 4'b0000}) + OFF_W'(r - 5'd8);
        // The unwrapped offset is always below twice the span, so one
        // conditional subtract implements the modulo.
        if (off >= OFF_W'(WIN_SPAN)) begin
            off = off - OFF_W'(WIN_SPAN);
        end
        return PHYS_W'(off) + PHYS_W'(8);
    endfunction

    // Upper WIM_In bits beyond NWINDOWS carry no meaning for this configuration.
    wire unused_wim_bits = &{1'b0, WIM_In};

    // Rotation targets and trap checks use the pre-edge WIM value.
    logic [4:0]          save_target;
    logic [4:0]          restore_target;
    logic                save_trap;
    logic                restore_trap;
    logic                cwp_load_ok;
    logic [PHYS_W-1:0]   write_addr;

    assign save_target    = (CWP == 5'd0) ? 5'(NWINDOWS - 1) : CWP - 5'd1;
    assign restore_target = (CWP == 5'(NWINDOWS - 1)) ? 5'd0 : CWP + 5'd1;
    assign save_trap      = |(WIM & (NWINDOWS'(1) << save_target));
    assign restore_trap   = |(WIM & (NWINDOWS'(1) << restore_target));
    // Six-bit compare so NWINDOWS=32 does not truncate the bound to zero.
    assign cwp_load_ok    = {1'b0, CWP_In} < 6'(NWINDOWS);
    assign write_addr     = map_addr(Register_C_Sel, CWP);

    // Combinational reads against the current window; r0 is hardwired to zero.
    assign Port_A = (Register_A_Sel == 5'd0) ? '0 : regs[map_addr(Register_A_Sel, CWP)];
    assign Port_B = (Register_B_Sel == 5'd0) ? '0 : regs[map_addr(Register_B_Sel, CWP)];

    // Register array: synchronous clear on reset, otherwise single write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the array is cleared on reset because software relies on
            // every physical register reading zero afterwards; this costs a
            // flop-based array rather than an inferred RAM.
            for (int i = 0; i < NPHYS; i++) begin
                regs[i] <= '0;
            end
        end else if (RF_Write && (Register_C_Sel != 5'd0)) begin
            // NOTE: non-blocking so the address decode above sees the CWP
            // from before this edge, even if CWP also changes on this edge.
            regs[write_addr] <= Data_In;
        end
    end

    // Window control: CWP load beats rotation, WIM load is independent,
    // and the trap flags are one-cycle registered pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CWP              <= 5'd0;
            WIM              <= '0;
            Window_Overflow  <= 1'b0;
            Window_Underflow <= 1'b0;
        end else begin
            Window_Overflow  <= 1'b0;
            Window_Underflow <= 1'b0;

            if (WIM_Load) begin
                WIM <= WIM_In[NWINDOWS-1:0];
            end

            if (CWP_Load) begin
                // An out-of-range load still claims priority; it simply
                // leaves CWP where it was.
                if (cwp_load_ok) begin
                    CWP <= CWP_In;
                end
            end else if (Save && Restore) begin
                // Conflicting strobes cancel: CWP holds and no trap is raised.
                CWP <= CWP;
            end else if (Save) begin
                if (save_trap) begin
                    Window_Overflow <= 1'b1;
                end else begin
                    CWP <= save_target;
                end
            end else if (Restore) begin
                if (restore_trap) begin
                    Window_Underflow <= 1'b1;
                end else begin
                    CWP <= restore_target;
                end
            end
        end
    end

endmodule

// File: doc/windowed_register_file.md
Name: windowed_register_file

Overview:
- SPARC integer register file with overlapping register windows; sits directly downstream of the register-address select muxes in the data path.
- Consumes the 5-bit architectural port A/B/write selects and maps them through the Current Window Pointer (CWP) to a physical array.
- Owns CWP and WIM state, executes SAVE/RESTORE window rotation, and flags window overflow/underflow to the control unit.

Parameters:
- NWINDOWS, 4, number of register windows (legal range 2..32); physical array holds 8 + 16*NWINDOWS words.
- DATA_W, 32, register word width.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Register_A_Sel  input  5  architectural address, read port A.
- Register_B_Sel  input  5  architectural address, read port B.
- Register_C_Sel  input  5  architectural address, write port.
- Data_In  input  DATA_W  write data.
- RF_Write  input  1  write enable.
- Save  input  1  SAVE strobe (CWP decrement).
- Restore  input  1  RESTORE strobe (CWP increment).
- CWP_Load  input  1  direct CWP load (WRPSR/trap entry).
- CWP_In  input  5  value for CWP_Load.
- WIM_Load  input  1  WIM load.
- WIM_In  input  32  value for WIM_Load; bits >= NWINDOWS ignored.
- Port_A  output  DATA_W  read data A.
- Port_B  output  DATA_W  read data B.
- CWP  output  5  current window pointer.
- WIM  output  NWINDOWS  window invalid mask.
- Window_Overflow  output  1  one-cycle pulse, SAVE into invalid window.
- Window_Underflow  output  1  one-cycle pulse, RESTORE into invalid window.

Behaviour:
- Address mapping, architectural r, window w:
  - r0..r7 are the globals and map to physical 0..7.
  - r8..r31 map to physical 8 + ((16*w + (r-8)) mod 16*NWINDOWS).
  - Consequence: the ins of window w are the outs of window (w+1) mod NWINDOWS.
- Reads:
  - Combinational from the current CWP and the stored array contents.
  - r0 always reads 0.
  - No write bypass: a write becomes visible on the cycle after its clock edge.
- Writes:
  - Occur on the rising edge when RF_Write=1.
  - The address is decoded with the CWP value before any same-cycle Save/Restore/CWP_Load.
  - Writes to r0 are discarded.
  - For SAVE/RESTORE, the control unit issues the rd writeback on the cycle after the strobe.
- CWP update priority, per edge, highest first:
  - CWP_Load: CWP <= CWP_In if CWP_In < NWINDOWS; otherwise the load is ignored.
  - Save and Restore both asserted: no-op; CWP unchanged; no flags.
  - Save: target t = (CWP-1) mod NWINDOWS. If WIM[t]=1, CWP is unchanged and Window_Overflow=1 for one cycle. Otherwise CWP <= t.
  - Restore: target t = (CWP+1) mod NWINDOWS. If WIM[t]=1, CWP is unchanged and Window_Underflow=1 for one cycle. Otherwise CWP <= t.
- Wrap-around: CWP=0 with Save goes to NWINDOWS-1; CWP=NWINDOWS-1 with Restore goes to 0.
- Trap check timing:
  - Uses the WIM value before any same-cycle WIM_Load.
  - WIM_Load updates WIM on the same edge: WIM <= WIM_In[NWINDOWS-1:0].
- Flags:
  - Registered, high for exactly one cycle per offending strobe.
  - Cleared on the next edge unless re-triggered.
- Reset (synchronous, highest priority over everything):
  - CWP=0, WIM=0, Window_Overflow=0, Window_Underflow=0.
  - All physical registers cleared to 0.
  - Port_A/Port_B therefore read 0 after the reset edge.
  - A write, Save or Restore coincident with Reset is discarded.

Test Plan:
1. Reset; read r0, r5, r17 -> all 0. Write r0=0xFFFFFFFF -> r0 still reads 0.
2. CWP=0: write r8=0xAAAA0001; Save -> CWP=3 (NWINDOWS=4); read r24 -> 0xAAAA0001. Restore -> CWP=0; r8 still 0xAAAA0001.
3. Write r3=0x12345678 at CWP=0; CWP_Load 2 -> r3 reads 0x12345678. Write r16=0x55 at CWP=2; CWP_Load 0 -> r16 reads 0.
4. WIM_Load 0x4:
   - At CWP=3, Save -> Window_Overflow high one cycle, CWP stays 3.
   - At CWP=1, Restore -> Window_Underflow high one cycle, CWP stays 1.
   - At CWP=0, Save -> CWP=3, no flag.
5. Same cycle Save+Restore at CWP=1 -> CWP=1, no flags. Same cycle CWP_Load=2+Save -> CWP=2. CWP_Load=7 with NWINDOWS=4 -> CWP unchanged.
6. With registers written and CWP=2, WIM=0x4, assert Reset coincident with RF_Write and Save -> next cycle CWP=0, WIM=0, flags 0, all reads 0.
